// File: rtl/rsqrt_nr_unit_if.sv
// rsqrt_nr_unit_if: handshake bundle for the FP16 reciprocal square root unit.
//   in_valid / in_ready / x       : operand request (master -> unit)
//   out_valid / out_ready / out   : result response (unit -> master)
//   converged                     : early exit taken, qualified by out_valid
//   iter_count                    : Newton-Raphson iterations executed, qualified by out_valid
interface rsqrt_nr_unit_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] x;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out;
   logic                  converged;
   logic [3:0]            iter_count;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, out, converged, iter_count
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, out, converged, iter_count
   );
endinterface

// File: rtl/rsqrt_nr_unit.sv
// rsqrt_nr_unit: iterative FP16 1/sqrt(x) engine, one Newton-Raphson step per clock.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   io    : rsqrt_nr_unit_if.slave (operand/result handshake, converged, iter_count)
// Flow: IDLE accepts x; special operands go straight to DONE, normal ones are seeded
// with SEED_MAGIC - (x >> 1) and iterate in ITER until MAX_ITER or |delta| <= CONV_THR
// (after MIN_ITER); DONE holds the result until out_ready.
module rsqrt_nr_unit #(
   parameter int          DATA_WIDTH = 16,
   parameter int          MAX_ITER   = 4,
   parameter int          MIN_ITER   = 1,
   parameter logic [14:0] CONV_THR   = 15'h0200,
   parameter logic [15:0] SEED_MAGIC = 16'h59BA
) (
   input logic           clk,
   input logic           reset,
   rsqrt_nr_unit_if.slave io
);

   localparam logic [15:0] FP_HALF     = 16'h3800;
   localparam logic [15:0] FP_THREEHLF = 16'h3E00;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   // FP16 multiply, round to nearest even. Subnormal operands/results flush to zero;
   // inf/NaN never reach the datapath because special operands bypass ITER.
   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic        s;
      logic [21:0] p;
      logic [10:0] m;
      logic        g;
      logic        st;
      int          e;
      s = a[15] ^ b[15];
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
      p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p[21]) begin
         m  = {1'b0, p[20:11]};
         g  = p[10];
         st = |p[9:0];
         e  = e + 1;
      end else begin
         m  = {1'b0, p[19:10]};
         g  = p[9];
         st = |p[8:0];
      end
      if (g && (st || m[0])) m = m + 11'd1;
      if (m[10]) begin
         m = 11'd0;
         e = e + 1;
      end
      if (e <= 0)  return {s, 15'd0};
      if (e >= 31) return {s, 5'h1F, 10'd0};
      return {s, e[4:0], m[9:0]};
   endfunction

   // FP16 add, round to nearest even, subnormals flushed. Mantissas carry 3 extra
   // bits (guard, round, sticky) so alignment shifts keep correct rounding.
   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] big;
      logic [15:0] sml;
      logic [13:0] mb;
      logic [13:0] ms;
      logic [14:0] sum;
      logic [10:0] m;
      logic        st;
      logic        g;
      logic        rs;
      int          e;
      int          d;
      st = 1'b0;
      if (b[14:10] == 5'd0) return (a[14:10] == 5'd0) ? 16'd0 : a;
      if (a[14:10] == 5'd0) return b;
      if (a[14:0] >= b[14:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      e  = int'(big[14:10]);
      d  = e - int'(sml[14:10]);
      mb = {1'b1, big[9:0], 3'b000};
      ms = {1'b1, sml[9:0], 3'b000};
      if (d > 13) begin
         ms = 14'd1;
      end else if (d > 0) begin
         for (int i = 0; i < 14; i++)
            if (i < d) st = st | ms[i];
         ms = (ms >> d) | {13'd0, st};
      end
      if (big[15] == sml[15]) begin
         sum = {1'b0, mb} + {1'b0, ms};
         if (sum[14]) begin
            sum = {1'b0, sum[14:1]} | {14'd0, sum[0]};
            e   = e + 1;
         end
      end else begin
         sum = {1'b0, mb} - {1'b0, ms};
         if (sum == 15'd0) return 16'd0;
         for (int i = 0; i < 13; i++)
            if (!sum[13]) begin
               sum = sum << 1;
               e   = e - 1;
            end
      end
      m  = {1'b0, sum[12:3]};
      g  = sum[2];
      rs = |sum[1:0];
      if (g && (rs || m[0])) m = m + 11'd1;
      if (m[10]) begin
         m = 11'd0;
         e = e + 1;
      end
      if (e <= 0)  return {big[15], 15'd0};
      if (e >= 31) return {big[15], 5'h1F, 10'd0};
      return {big[15], e[4:0], m[9:0]};
   endfunction

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] xr, xr_n;
   logic [DATA_WIDTH-1:0] y, y_n;
   logic [DATA_WIDTH-1:0] out_r, out_n;
   logic [3:0]            cnt, cnt_n;
   logic [3:0]            itc_r, itc_n;
   logic                  conv_r, conv_n;

   // One Newton-Raphson step. Evaluated as ((x*y)*y)*0.5 rather than (0.5*x)*y*y
   // so no intermediate drops into the subnormal range at either end of the input span.
   logic [DATA_WIDTH-1:0] xy, xyy, half_xyy, corr, y_new, delta;
   logic [3:0]            cnt_inc;
   logic                  small_delta;

   always_comb begin
      xy          = fmul(xr, y);
      xyy         = fmul(xy, y);
      half_xyy    = fmul(xyy, FP_HALF);
      corr        = fadd(FP_THREEHLF, half_xyy ^ 16'h8000);
      y_new       = fmul(y, corr);
      delta       = fadd(y_new, y ^ 16'h8000);
      cnt_inc     = cnt + 4'd1;
      small_delta = (delta & 16'h7FFF) <= {1'b0, CONV_THR};
   end

   // Operand classification for the IDLE capture
   logic                  special;
   logic [DATA_WIDTH-1:0] special_out;

   always_comb begin
      special     = 1'b1;
      special_out = 16'h7E00;
      if (io.x[14:10] == 5'd0)
         special_out = 16'h7C00;                 // +-0 and subnormals
      else if (io.x[14:10] == 5'h1F && io.x[9:0] != 10'd0)
         special_out = 16'h7E00;                 // NaN
      else if (io.x[15])
         special_out = 16'h7E00;                 // negative nonzero, including -inf
      else if (io.x[14:10] == 5'h1F)
         special_out = 16'h0000;                 // +inf
      else
         special = 1'b0;
   end

   always_comb begin
      state_n = state;
      xr_n    = xr;
      y_n     = y;
      cnt_n   = cnt;
      out_n   = out_r;
      itc_n   = itc_r;
      conv_n  = conv_r;
      unique case (state)
         IDLE: begin
            if (io.in_valid) begin
               xr_n = io.x;
               if (special) begin
                  out_n   = special_out;
                  itc_n   = 4'd0;
                  conv_n  = 1'b0;
                  state_n = DONE;
               end else begin
                  y_n     = SEED_MAGIC - {1'b0, io.x[15:1]};
                  cnt_n   = 4'd0;
                  state_n = ITER;
               end
            end
         end
         ITER: begin
            y_n   = y_new;
            cnt_n = cnt_inc;
            // Hitting MAX_ITER wins over convergence: converged marks an early exit only.
            if (int'(cnt_inc) == MAX_ITER) begin
               out_n   = y_new;
               itc_n   = cnt_inc;
               conv_n  = 1'b0;
               state_n = DONE;
            end else if (int'(cnt_inc) >= MIN_ITER && small_delta) begin
               out_n   = y_new;
               itc_n   = cnt_inc;
               conv_n  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            if (io.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         xr     <= '0;
         y      <= '0;
         cnt    <= '0;
         out_r  <= '0;
         itc_r  <= '0;
         conv_r <= 1'b0;
      end else begin
         state  <= state_n;
         xr     <= xr_n;
         y      <= y_n;
         cnt    <= cnt_n;
         out_r  <= out_n;
         itc_r  <= itc_n;
         conv_r <= conv_n;
      end
   end

   assign io.in_ready   = (state == IDLE);
   assign io.out_valid  = (state == DONE);
   assign io.out        = out_r;
   assign io.converged  = conv_r;
   assign io.iter_count = itc_r;

endmodule

// File: tb/tb_rsqrt_nr_unit.sv
// tb_rsqrt_nr_unit: directed self-checking bench for rsqrt_nr_unit.
// dut_a uses default parameters; dut_b is a MAX_ITER=1, CONV_THR=0 build.
module tb_rsqrt_nr_unit;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   rsqrt_nr_unit_if ifa ();
   rsqrt_nr_unit_if ifb ();

   rsqrt_nr_unit dut_a (
      .clk   (clk),
      .reset (reset),
      .io    (ifa)
   );

   rsqrt_nr_unit #(
      .MAX_ITER (1),
      .CONV_THR (15'h0000)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .io    (ifb)
   );

   function automatic int udiff(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? int'(a - b) : int'(b - a);
   endfunction

   // Drives one operation on dut_a with out_ready high; lat counts edges from the
   // capture edge up to the first cycle out_valid is seen (capped at 20).
   task automatic op_a(input logic [15:0] xin, output logic [15:0] res,
                       output logic [3:0] itc, output logic cv, output int lat);
      @(posedge clk); #1;
      ifa.x         = xin;
      ifa.in_valid  = 1'b1;
      ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      lat = 1;
      while (!ifa.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = ifa.out;
      itc = ifa.iter_count;
      cv  = ifa.converged;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      tests++; if (ifa.in_ready !== 1'b1)   begin fails++; $display("FAIL reset_in_ready got %b want 1", ifa.in_ready); end
      tests++; if (ifa.out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
      tests++; if (ifa.out !== 16'h0000)    begin fails++; $display("FAIL reset_out got %h want 0000", ifa.out); end
      tests++; if (ifa.converged !== 1'b0)  begin fails++; $display("FAIL reset_converged got %b want 0", ifa.converged); end
      tests++; if (ifa.iter_count !== 4'd0) begin fails++; $display("FAIL reset_iter_count got %0d want 0", ifa.iter_count); end
   endtask

   task automatic test_basic;
      int lat;
      @(posedge clk); #1;
      ifa.x = 16'h4400; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      tests++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready_drop got %b want 0", ifa.in_ready); end
      lat = 1;
      while (!ifa.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++; if (lat > 5) begin fails++; $display("FAIL basic_latency got %0d want <=5", lat); end
      tests++; if (udiff(ifa.out, 16'h3800) > 2) begin fails++; $display("FAIL basic_out got %h want 3800+-2", ifa.out); end
      tests++; if (ifa.iter_count < 4'd1 || ifa.iter_count > 4'd4) begin fails++; $display("FAIL basic_iter_count got %0d want 1..4", ifa.iter_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_values;
      logic [15:0] xs  [6] = '{16'h3C00, 16'h4C00, 16'h3400, 16'h7BFF, 16'h0400, 16'h4400};
      logic [15:0] exs [6] = '{16'h3C00, 16'h3400, 16'h4000, 16'h1C00, 16'h5800, 16'h3800};
      logic [15:0] res;
      logic [3:0]  itc;
      logic        cv;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         op_a(xs[i], res, itc, cv, lat);
         tests++; if (udiff(res, exs[i]) > 2) begin fails++; $display("FAIL value_out x=%h got %h want %h+-2", xs[i], res, exs[i]); end
         tests++; if (lat != int'(itc) + 1) begin fails++; $display("FAIL value_latency x=%h got %0d want %0d", xs[i], lat, int'(itc) + 1); end
         tests++; if (cv ? (itc < 4'd1 || itc > 4'd3) : (itc != 4'd4)) begin fails++; $display("FAIL value_conv x=%h got conv=%b iter=%0d", xs[i], cv, itc); end
      end
   endtask

   task automatic test_special;
      logic [15:0] xs  [7] = '{16'h0000, 16'h8000, 16'h0001, 16'hC400, 16'h7C00, 16'h7E01, 16'hFC00};
      logic [15:0] exs [7] = '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7E00, 16'h0000, 16'h7E00, 16'h7E00};
      logic [15:0] res;
      logic [3:0]  itc;
      logic        cv;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         op_a(xs[i], res, itc, cv, lat);
         tests++; if (res !== exs[i]) begin fails++; $display("FAIL special_out x=%h got %h want %h", xs[i], res, exs[i]); end
         tests++; if (itc !== 4'd0 || cv !== 1'b0) begin fails++; $display("FAIL special_flags x=%h got iter=%0d conv=%b want 0/0", xs[i], itc, cv); end
         tests++; if (lat != 1) begin fails++; $display("FAIL special_latency x=%h got %0d want 1", xs[i], lat); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] r1, r2;
      int          got, n, c1;
      bit          overlap, gap_bad;
      r1 = '0; r2 = '0; got = 0; n = 0; c1 = -10; overlap = 0; gap_bad = 0;
      @(posedge clk); #1;
      ifa.x = 16'h3C00; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.x = 16'h4C00;
      while (got < 2 && n < 30) begin
         if (ifa.in_ready && ifa.out_valid) overlap = 1;
         if (n == c1 + 1 && !(ifa.in_ready && !ifa.out_valid)) gap_bad = 1;
         if (ifa.out_valid) begin
            if (got == 0) begin r1 = ifa.out; c1 = n; end
            else r2 = ifa.out;
            got++;
            if (got == 2) ifa.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      tests++; if (got != 2) begin fails++; $display("FAIL b2b_count got %0d want 2", got); end
      tests++; if (udiff(r1, 16'h3C00) > 2) begin fails++; $display("FAIL b2b_first got %h want 3C00+-2", r1); end
      tests++; if (udiff(r2, 16'h3400) > 2) begin fails++; $display("FAIL b2b_second got %h want 3400+-2", r2); end
      tests++; if (overlap || gap_bad) begin fails++; $display("FAIL b2b_accept_order got overlap=%b gap=%b want 0/0", overlap, gap_bad); end
   endtask

   task automatic test_backpressure;
      logic [15:0] held;
      int          n;
      bit          unstable;
      @(posedge clk); #1;
      ifa.x = 16'h4400; ifa.in_valid = 1'b1; ifa.out_ready = 1'b0;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      n = 0;
      while (!ifa.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      held = ifa.out;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         ifa.x = 16'h0000; ifa.in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         if (!ifa.out_valid || ifa.out !== held || ifa.in_ready) unstable = 1;
      end
      tests++; if (unstable) begin fails++; $display("FAIL bp_stable got unstable outputs/in_ready want held"); end
      tests++; if (udiff(held, 16'h3800) > 2) begin fails++; $display("FAIL bp_out got %h want 3800+-2", held); end
      ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", ifa.out_valid, ifa.in_ready); end
      tests++; if (ifa.out !== held) begin fails++; $display("FAIL bp_out_hold got %h want %h", ifa.out, held); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] res;
      logic [3:0]  itc;
      logic        cv;
      int          lat;
      @(posedge clk); #1;
      ifa.x = 16'h4400; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", ifa.in_ready); end
      #1 reset = 1'b1;
      #1;
      tests++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_async got ready=%b valid=%b want 1/0", ifa.in_ready, ifa.out_valid); end
      tests++; if (ifa.out !== 16'h0000) begin fails++; $display("FAIL rst_mid_out got %h want 0000", ifa.out); end
      @(negedge clk);
      reset = 1'b0;
      op_a(16'h3C00, res, itc, cv, lat);
      tests++; if (udiff(res, 16'h3C00) > 2 || lat > 5) begin fails++; $display("FAIL rst_mid_recover got %h lat %0d want 3C00+-2 lat<=5", res, lat); end
   endtask

   task automatic test_max_iter1;
      int lat;
      @(posedge clk); #1;
      ifb.x = 16'h4400; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
      @(posedge clk); #1;
      ifb.in_valid = 1'b0;
      lat = 1;
      while (!ifb.out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      tests++; if (lat != 2) begin fails++; $display("FAIL max1_latency got %0d want 2", lat); end
      tests++; if (ifb.iter_count !== 4'd1) begin fails++; $display("FAIL max1_iter_count got %0d want 1", ifb.iter_count); end
      tests++; if (ifb.converged !== 1'b0) begin fails++; $display("FAIL max1_converged got %b want 0", ifb.converged); end
      // One step from seed 0x37BA: 0.48291*(1.5-2*0.48291^2) = 0.49914 -> 0x37FC
      tests++; if (udiff(ifb.out, 16'h37FC) > 2) begin fails++; $display("FAIL max1_out got %h want 37FC+-2", ifb.out); end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      ifa.in_valid = 1'b0; ifa.x = '0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.x = '0; ifb.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      reset = 1'b0;
      test_basic;
      test_values;
      test_special;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_max_iter1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
